// File: rtl/tow_round_tally.sv
// tow_round_tally: counts round wins per player, shows each tally on an
// active-low 7-segment digit, requests a round reset after a display
// interval and stops once a player reaches MAX_WINS.
// Optional build macro: TOW_TALLY_BLINK_EN (winner digit blinks in DONE).
//
// state | meaning
// ------+-------------------------------------------------------------
// PLAY  | waiting for a win rise; counts it and loads the hold timer
// HOLD  | victor shown for HOLD_CYCLES cycles
// CLEAR | round_reset asserted until both win flags are low
// DONE  | match over; absorbing until reset
module tow_round_tally #(
    parameter int MAX_WINS     = 3,
    parameter int HOLD_CYCLES  = 4,
    parameter int BLINK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win1,
    input  logic       win2,
    output logic       round_reset,
    output logic       match_over,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    localparam int CW = $clog2(MAX_WINS + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_WINS);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    if (MAX_WINS < 1 || MAX_WINS > 9 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
        $error("tow_round_tally: parameter out of legal range");
    end

    typedef enum logic [1:0] {PLAY, HOLD, CLEAR, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt1, cnt2;
    logic [TW-1:0] timer;
    logic          win1_d, win2_d;
    logic          rise1, rise2;
    logic          inc1, inc2, load_timer;

    assign rise1 = win1 & ~win1_d;
    assign rise2 = win2 & ~win2_d;

    // Next-state decode plus the count/timer load strobes taken from PLAY
    always_comb begin
        next_state = state;
        inc1       = 1'b0;
        inc2       = 1'b0;
        load_timer = 1'b0;
        case (state)
            PLAY: begin
                if (rise1 || rise2) begin
                    load_timer = 1'b1;
                    inc1       = rise1 & ~rise2;
                    inc2       = rise2 & ~rise1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (timer == '0) begin
                    next_state = (cnt1 == MAX_CNT || cnt2 == MAX_CNT) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                if (!win1 && !win2) next_state = PLAY;
            end
            DONE:    next_state = DONE;
            default: next_state = PLAY;
        endcase
    end

    // State, tallies, hold timer and win edge-detect flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PLAY;
            cnt1   <= '0;
            cnt2   <= '0;
            timer  <= '0;
            win1_d <= 1'b0;
            win2_d <= 1'b0;
        end else begin
            state  <= next_state;
            win1_d <= win1;
            win2_d <= win2;
            if (inc1 && cnt1 != MAX_CNT) cnt1 <= cnt1 + 1'b1;
            if (inc2 && cnt2 != MAX_CNT) cnt2 <= cnt2 + 1'b1;
            if (load_timer)                          timer <= HOLD_LOAD;
            else if (state == HOLD && timer != '0)   timer <= timer - 1'b1;
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    assign round_reset = (state == CLEAR);
    assign match_over  = (state == DONE);

`ifdef TOW_TALLY_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Free-running blink down-counter; restarted with phase 0 on DONE entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= BLINK_LOAD;
            phase     <= 1'b0;
        end else if (next_state == DONE && state != DONE) begin
            blink_cnt <= BLINK_LOAD;
            phase     <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= BLINK_LOAD;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    // Digit decode; the winner's digit is blanked during the blink-off phase
    always_comb begin
        hex1 = seg(4'(cnt1));
        hex2 = seg(4'(cnt2));
        if (state == DONE && phase) begin
            if (cnt1 == MAX_CNT) hex1 = 7'b1111111;
            if (cnt2 == MAX_CNT) hex2 = 7'b1111111;
        end
    end
`else
    // Steady digit decode of both tallies
    always_comb begin
        hex1 = seg(4'(cnt1));
        hex2 = seg(4'(cnt2));
    end
`endif

endmodule
